// File: rtl/logic_op_engine_if.sv
// Request/response bus for logic_op_engine.
// Optional macro LOGIC_OP_PARITY_EN adds the rsp_parity signal.
interface logic_op_engine_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_sel;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero;
`ifdef LOGIC_OP_PARITY_EN
  logic       rsp_parity;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_parity
  );
  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_parity
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );
  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );
`endif
endinterface

// File: rtl/logic_op_engine.sv
// Logic-op engine: computes AND/XOR/OR/NOT of 8-bit operands into a 2-entry
// result FIFO with valid/ready handshakes and a completed-response counter.
// Optional macro LOGIC_OP_PARITY_EN adds an even-parity output on the head.
module logic_op_engine #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  logic_op_engine_if.slave   bus,
  output logic [CNT_W-1:0]   op_count
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       head_q, head_d;
  logic [7:0]       tail_q, tail_d;
  logic             head_we;
  logic             zero_q;
  logic             ready_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       result;
  logic             push, pop;

  // clr wins over both push and pop
  assign push = bus.req_valid & ready_q & ~clr;
  assign pop  = (state_q != StEmpty) & bus.rsp_ready & ~clr;

  // Operation decode
  always_comb begin
    result = 8'h00;
    unique case (bus.req_sel)
      2'b00:   result = bus.req_a & bus.req_b;
      2'b01:   result = bus.req_a ^ bus.req_b;
      2'b10:   result = bus.req_a | bus.req_b;
      default: result = ~bus.req_b;
    endcase
  end

  // Occupancy FSM and FIFO entry next-state
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    head_we = 1'b0;
    if (clr) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (push) begin
            state_d = StOne;
            head_d  = result;
            head_we = 1'b1;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_d  = result;
            head_we = 1'b1;
          end else if (push) begin
            state_d = StFull;
            tail_d  = result;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // req_ready is low here, so only a pop can happen
          if (pop) begin
            state_d = StOne;
            head_d  = tail_q;
            head_we = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State, buffer, registered ready/zero flags and handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= 8'h00;
      tail_q  <= 8'h00;
      zero_q  <= 1'b0;
      ready_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      // zero flag tracks writes only, so it stays low out of reset
      if (head_we) zero_q <= (head_d == 8'h00);
      ready_q <= (state_d != StFull);
      if (pop) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state_q != StEmpty);
  assign bus.rsp_data  = head_q;
  assign bus.rsp_zero  = zero_q;
  assign op_count      = count_q;
`ifdef LOGIC_OP_PARITY_EN
  assign bus.rsp_parity = ^head_q;
`endif

endmodule

// File: tb/tb_logic_op_engine.sv
// Directed self-checking bench for logic_op_engine (CNT_W = 4).
module tb_logic_op_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [3:0] op_count;
  int         n_cmp = 0;
  int         n_mis = 0;

  logic_op_engine_if bus();

  logic_op_engine #(.CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_valid got %0h want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 8'h00) begin n_mis++; $display("FAIL reset_rsp_data got %0h want 00", bus.rsp_data); end
    n_cmp++; if (bus.rsp_zero !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_zero got %0h want 0", bus.rsp_zero); end
    n_cmp++; if (op_count !== 4'd0) begin n_mis++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_mis++; $display("FAIL reset_req_ready got %0h want 0", bus.req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_mis++; $display("FAIL release_ready_early got %0h want 0", bus.req_ready); end
    step();
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL release_ready got %0h want 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL release_rsp_valid got %0h want 0", bus.rsp_valid); end
  endtask

  // All four ops streamed with rsp_ready=1: push+pop each cycle in state ONE
  task automatic test_all_ops();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'hFF; exp_d[3] = 8'hAA;
    bus.rsp_ready = 1'b1;
    bus.req_a     = 8'hAA;
    bus.req_b     = 8'h55;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_sel = 2'(i);
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_mis++; $display("FAIL ops_valid[%0d] got %0h want 1", i, bus.rsp_valid); end
      n_cmp++; if (bus.rsp_data !== exp_d[i]) begin n_mis++; $display("FAIL ops_data[%0d] got %0h want %0h", i, bus.rsp_data, exp_d[i]); end
      n_cmp++; if (bus.rsp_zero !== (i == 0)) begin n_mis++; $display("FAIL ops_zero[%0d] got %0h want %0h", i, bus.rsp_zero, (i == 0)); end
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL ops_ready[%0d] got %0h want 1", i, bus.req_ready); end
    end
    bus.req_valid = 1'b0;
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL ops_drain got %0h want 0", bus.rsp_valid); end
    n_cmp++; if (op_count !== 4'd4) begin n_mis++; $display("FAIL ops_count got %0d want 4", op_count); end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'b00;
    step();
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL bp_ready1 got %0h want 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_data !== 8'h00) begin n_mis++; $display("FAIL bp_data1 got %0h want 00", bus.rsp_data); end
    bus.req_sel = 2'b01;
    step();
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_mis++; $display("FAIL bp_full_ready got %0h want 0", bus.req_ready); end
    bus.req_sel = 2'b10;
    step();
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_mis++; $display("FAIL bp_hold_ready got %0h want 0", bus.req_ready); end
    n_cmp++; if (bus.rsp_data !== 8'h00 || bus.rsp_zero !== 1'b1) begin n_mis++; $display("FAIL bp_stable got %0h/%0h want 00/1", bus.rsp_data, bus.rsp_zero); end
    bus.rsp_ready = 1'b1;
    step();
    n_cmp++; if (bus.rsp_data !== 8'hFF) begin n_mis++; $display("FAIL bp_second got %0h want ff", bus.rsp_data); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL bp_ready_back got %0h want 1", bus.req_ready); end
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hFF) begin n_mis++; $display("FAIL bp_third got %0h/%0h want 1/ff", bus.rsp_valid, bus.rsp_data); end
    bus.req_valid = 1'b0;
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL bp_no_dup got %0h want 0", bus.rsp_valid); end
    n_cmp++; if (op_count !== 4'd7) begin n_mis++; $display("FAIL bp_count got %0d want 7", op_count); end
  endtask

  task automatic test_clr();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'b01;
    step();
    clr         = 1'b1;
    bus.req_sel = 2'b11;
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL clr_one_valid got %0h want 0", bus.rsp_valid); end
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL clr_one_noaccept got %0h want 0", bus.rsp_valid); end
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'b01;
    step();
    bus.req_sel = 2'b11;
    step();
    n_cmp++; if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin n_mis++; $display("FAIL clr_full_setup got %0h/%0h want 0/1", bus.req_ready, bus.rsp_valid); end
    clr           = 1'b1;
    bus.rsp_ready = 1'b1;
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL clr_full_valid got %0h want 0", bus.rsp_valid); end
    n_cmp++; if (op_count !== 4'd7) begin n_mis++; $display("FAIL clr_count got %0d want 7", op_count); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL clr_ready got %0h want 1", bus.req_ready); end
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b0 || op_count !== 4'd7) begin n_mis++; $display("FAIL clr_after got %0h/%0d want 0/7", bus.rsp_valid, op_count); end
  endtask

  task automatic test_wrap_reset();
    bus.rsp_ready = 1'b1;
    bus.req_sel   = 2'b00;
    bus.req_valid = 1'b1;
    repeat (8) step();
    bus.req_valid = 1'b0;
    step();
    n_cmp++; if (op_count !== 4'd15) begin n_mis++; $display("FAIL wrap_pre got %0d want 15", op_count); end
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    n_cmp++; if (op_count !== 4'd0) begin n_mis++; $display("FAIL wrap_zero got %0d want 0", op_count); end
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'b11;
    step();
    step();
    bus.req_valid = 1'b0;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin n_mis++; $display("FAIL rst_setup got %0h/%0h want 1/0", bus.rsp_valid, bus.req_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_zero !== 1'b0) begin n_mis++; $display("FAIL rst_mid_rsp got %0h/%0h/%0h want 0/00/0", bus.rsp_valid, bus.rsp_data, bus.rsp_zero); end
    n_cmp++; if (op_count !== 4'd0 || bus.req_ready !== 1'b0) begin n_mis++; $display("FAIL rst_mid_misc got %0d/%0h want 0/0", op_count, bus.req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL rst_after got %0h/%0h want 1/0", bus.req_ready, bus.rsp_valid); end
    bus.rsp_ready = 1'b1;
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b0 || op_count !== 4'd0) begin n_mis++; $display("FAIL rst_no_stale got %0h/%0d want 0/0", bus.rsp_valid, op_count); end
  endtask

  task automatic test_parity();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'b11;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h55;
    step();
    n_cmp++; if (bus.rsp_data !== 8'hAA) begin n_mis++; $display("FAIL par_not_data got %0h want aa", bus.rsp_data); end
`ifdef LOGIC_OP_PARITY_EN
    n_cmp++; if (bus.rsp_parity !== 1'b0) begin n_mis++; $display("FAIL par_not got %0h want 0", bus.rsp_parity); end
`endif
    bus.req_sel = 2'b00;
    bus.req_a   = 8'h07;
    bus.req_b   = 8'h03;
    step();
    n_cmp++; if (bus.rsp_data !== 8'h03) begin n_mis++; $display("FAIL par_and_data got %0h want 03", bus.rsp_data); end
`ifdef LOGIC_OP_PARITY_EN
    n_cmp++; if (bus.rsp_parity !== 1'b0) begin n_mis++; $display("FAIL par_and got %0h want 0", bus.rsp_parity); end
`endif
    bus.req_sel = 2'b01;
    bus.req_a   = 8'h01;
    bus.req_b   = 8'h00;
    step();
    n_cmp++; if (bus.rsp_data !== 8'h01) begin n_mis++; $display("FAIL par_xor_data got %0h want 01", bus.rsp_data); end
`ifdef LOGIC_OP_PARITY_EN
    n_cmp++; if (bus.rsp_parity !== 1'b1) begin n_mis++; $display("FAIL par_xor got %0h want 1", bus.rsp_parity); end
`endif
    bus.req_valid = 1'b0;
    step();
    n_cmp++; if (op_count !== 4'd3) begin n_mis++; $display("FAIL par_count got %0d want 3", op_count); end
  endtask

  initial begin
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.req_sel   = 2'b00;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_all_ops();
    test_backpressure();
    test_clr();
    test_wrap_reset();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/logic_op_engine.md
LOGIC_OP_ENGINE -- requirements
Module: logic_op_engine

Interface
REQ-001 SHALL have parameter CNT_W, default 16, which sets the width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port clr  input  1  synchronous flush of the result buffer.
REQ-005 SHALL have port req_valid  input  1  the requester presents an operation.
REQ-006 SHALL have port req_ready  output  1  the engine can accept an operation (registered).
REQ-007 SHALL have port req_a  input  8  operand A.
REQ-008 SHALL have port req_b  input  8  operand B.
REQ-009 SHALL have port req_sel  input  2  operation select.
REQ-010 SHALL have port rsp_valid  output  1  result available at the buffer head.
REQ-011 SHALL have port rsp_ready  input  1  the consumer takes the result.
REQ-012 SHALL have port rsp_data  output  8  head result.
REQ-013 SHALL have port rsp_zero  output  1  high when rsp_data equals 8'h00.
REQ-014 SHALL have port op_count  output  CNT_W  count of completed response handshakes.

Function
REQ-015 SHALL compute by req_sel: 00 = A AND B; 01 = A XOR B; 10 = A OR B; 11 = NOT B (A ignored).
REQ-016 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, writing the result into a 2-entry FIFO at that edge.
REQ-017 SHALL give 1-cycle latency: on an empty buffer, rsp_valid=1 with the result on the cycle after acceptance.
REQ-018 SHALL complete a response on a rising edge with rsp_valid=1 and rsp_ready=1, popping the head.
REQ-019 SHALL use occupancy FSM states EMPTY, ONE, FULL with transitions:
- EMPTY + push -> ONE.
- ONE + push only -> FULL.
- ONE + pop only -> EMPTY.
- ONE + push and pop -> ONE, with the new result becoming the head on the next cycle.
- FULL + pop -> ONE.
- All other cases hold the current state.
REQ-020 SHALL drive req_ready next = (next state != FULL), so no push occurs in FULL even when rsp_ready=1.
REQ-021 SHALL drive rsp_valid = (state != EMPTY), with rsp_data and rsp_zero stable while rsp_valid=1 and rsp_ready=0.
REQ-022 SHALL preserve request order: results are returned in acceptance order.
REQ-023 SHALL increment op_count by 1 on each response handshake, wrapping from all-ones to 0.
REQ-024 SHALL give clr=1 priority over push and pop: the buffer is emptied (EMPTY, rsp_valid=0), no request is accepted, no pop is counted, and op_count is unchanged.
REQ-025 SHALL keep a request held by the requester with req_ready=0 pending until accepted; the engine neither drops nor duplicates it.

Reset
REQ-026 SHALL on rst_n=0 immediately set:
- state = EMPTY;
- rsp_valid = 0, rsp_data = 8'h00, rsp_zero = 0;
- op_count = 0;
- req_ready = 0.
REQ-027 SHALL raise req_ready to 1 on the first rising clk edge after rst_n deasserts.
REQ-028 SHALL discard buffered results when reset is asserted mid-operation; no response from before reset appears afterward.

Configuration
REQ-029 SHALL add output rsp_parity (1 bit, even parity = XOR of rsp_data bits) when LOGIC_OP_PARITY_EN is defined; it follows rsp_data and resets to 0.
REQ-030 SHALL have no rsp_parity port and no parity logic when LOGIC_OP_PARITY_EN is undefined; all other behaviour is identical.

Verification
REQ-031 SHALL cover all four ops with A=8'hAA, B=8'h55 and rsp_ready=1: AND -> 8'h00 with rsp_zero=1; XOR -> 8'hFF; OR -> 8'hFF; NOT -> 8'hAA; each result appears 1 cycle after acceptance; op_count ends at 4.
REQ-032 SHALL cover backpressure: rsp_ready=0, three back-to-back requests (AND, XOR, OR of AA/55) -> first two accepted, req_ready=0 on the third; then rsp_ready=1 -> responses 00, FF, FF in order, the third request accepted exactly once.
REQ-033 SHALL cover simultaneous push and pop in state ONE with rsp_ready=1 and a continuous request stream -> one result per cycle, req_ready stays 1, state stays ONE.
REQ-034 SHALL cover clr in state FULL with req_valid=1 -> state EMPTY next cycle, rsp_valid=0, op_count unchanged, request not accepted that cycle.
REQ-035 SHALL cover counter wrap and reset: preload op_count to all-ones via 2^CNT_W-1 handshakes (or CNT_W=4 with 15), one more handshake -> 0; then assert rst_n=0 with 2 results buffered -> all outputs reset and no stale responses afterward.
REQ-036 SHALL cover parity with LOGIC_OP_PARITY_EN defined: NOT op with B=8'h55 -> rsp_data 8'hAA, rsp_parity=0; AND op with A=8'h07, B=8'h03 -> 8'h03, rsp_parity=0; XOR op with A=8'h01, B=8'h00 -> 8'h01, rsp_parity=1.
